// File: rtl/mm_control_multi.sv
// rtl/mm_control_multi.sv - multi-channel HPS start/done control block with sticky done flags and IRQ
// Optional watchdog per channel in WAIT: define MMC_TIMEOUT_EN.
module mm_control_multi #(
   parameter int WIDTH          = 8,
   parameter int CHANNELS       = 4,
   parameter int ADDR_WIDTH     = 2,
   parameter int START_PULSE    = 20,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  read,
   input  logic                  write,
   input  logic [WIDTH-1:0]      data_write,
   output logic [WIDTH-1:0]      data_read,
   output logic [CHANNELS-1:0]   start_out,
   input  logic [CHANNELS-1:0]   done_in,
   output logic                  interrupt_internal
);

   localparam int PW = $clog2(START_PULSE + 1);
   localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_MASK   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_ERROR  = ADDR_WIDTH'(3);

   typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} ch_state_t;

   ch_state_t           state_q [CHANNELS];
   ch_state_t           state_d [CHANNELS];
   logic [PW-1:0]       pcnt_q  [CHANNELS];
   logic [PW-1:0]       pcnt_d  [CHANNELS];
   logic [CHANNELS-1:0] latch_q, latch_d;
   logic [CHANNELS-1:0] done_set, err_set, busy, start_req;
   logic [CHANNELS-1:0] done_q, err_q, mask_q;
   logic [WIDTH-1:0]    rd_val;
   logic                irq_q;
   logic                unused_data;

`ifdef MMC_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]       wcnt_q [CHANNELS];
   logic [TW-1:0]       wcnt_d [CHANNELS];
`endif

   assign unused_data = ^data_write;
   assign start_req   = (write && address == A_CTRL) ? data_write[CHANNELS-1:0] : '0;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i]  = state_q[i];
         pcnt_d[i]   = pcnt_q[i];
         latch_d[i]  = latch_q[i];
         done_set[i] = 1'b0;
         err_set[i]  = 1'b0;
`ifdef MMC_TIMEOUT_EN
         wcnt_d[i]   = wcnt_q[i];
`endif
         case (state_q[i])
            IDLE: begin
               if (start_req[i]) begin
                  state_d[i] = PULSE;
                  pcnt_d[i]  = PW'(START_PULSE - 1);
                  latch_d[i] = 1'b0;
               end
            end
            PULSE: begin
               // a completion seen anywhere in the pulse skips WAIT entirely
               if (pcnt_q[i] == '0) begin
                  if (latch_q[i] || done_in[i]) begin
                     state_d[i]  = DONE;
                     done_set[i] = 1'b1;
                  end else begin
                     state_d[i]  = WAIT;
                  end
`ifdef MMC_TIMEOUT_EN
                  wcnt_d[i] = '0;
`endif
               end else begin
                  pcnt_d[i]  = pcnt_q[i] - 1'b1;
                  latch_d[i] = latch_q[i] | done_in[i];
               end
            end
            WAIT: begin
               if (done_in[i]) begin
                  state_d[i]  = DONE;
                  done_set[i] = 1'b1;
               end
`ifdef MMC_TIMEOUT_EN
               else if (wcnt_q[i] == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_d[i]  = DONE;
                  done_set[i] = 1'b1;
                  err_set[i]  = 1'b1;
               end else begin
                  wcnt_d[i] = wcnt_q[i] + 1'b1;
               end
`endif
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         busy[i]      = (state_q[i] != IDLE);
         start_out[i] = (state_q[i] == PULSE);
      end
   end

   always_comb begin
      rd_val = '0;
      case (address)
         A_CTRL:   rd_val = WIDTH'(busy);
         A_STATUS: rd_val = WIDTH'(done_q);
         A_MASK:   rd_val = WIDTH'(mask_q);
         A_ERROR:  rd_val = WIDTH'(err_q);
         default:  rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= IDLE;
            pcnt_q[i]  <= '0;
`ifdef MMC_TIMEOUT_EN
            wcnt_q[i]  <= '0;
`endif
         end
         latch_q   <= '0;
         done_q    <= '0;
         err_q     <= '0;
         mask_q    <= '0;
         irq_q     <= 1'b0;
         data_read <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            pcnt_q[i]  <= pcnt_d[i];
`ifdef MMC_TIMEOUT_EN
            wcnt_q[i]  <= wcnt_d[i];
`endif
         end
         latch_q <= latch_d;
         // a flag set on the same edge as its read-clear survives
         done_q  <= ((read && address == A_STATUS) ? '0 : done_q) | done_set;
         err_q   <= ((read && address == A_ERROR)  ? '0 : err_q)  | err_set;
         if (write && address == A_MASK) mask_q <= data_write[CHANNELS-1:0];
         irq_q   <= |(done_q & mask_q);
         if (read) data_read <= rd_val;
      end
   end

   assign interrupt_internal = irq_q;

endmodule

// File: tb/tb_mm_control_multi.sv
// tb/tb_mm_control_multi.sv - self-checking bench for mm_control_multi
// Timeout scenario runs when MMC_TIMEOUT_EN is defined.
module tb_mm_control_multi;

   localparam int SP = 20;
   localparam int TO = 16;
`ifdef MMC_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] address = '0;
   logic       read = 1'b0;
   logic       write = 1'b0;
   logic [7:0] data_write = '0;
   logic [7:0] data_read;
   logic [3:0] start_out;
   logic [3:0] done_in = '0;
   logic       interrupt_internal;

   int total = 0;
   int bad = 0;

   mm_control_multi #(.WIDTH(8), .CHANNELS(4), .ADDR_WIDTH(2), .START_PULSE(SP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .data_write(data_write), .data_read(data_read), .start_out(start_out),
      .done_in(done_in), .interrupt_internal(interrupt_internal));

   always #5 clk = ~clk;

   // Reference: each channel is either pulsing (cycles left), waiting (age), in its done cycle, or idle.
   int         pl [4];
   int         wa [4];
   bit         wt [4];
   bit         sn [4];
   bit         dc [4];
   logic [3:0] m_done, m_err, m_mask, m_busy, m_nd, m_ne;
   logic       m_irq;
   logic [7:0] m_rd;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin pl[i] = 0; wa[i] = 0; wt[i] = 0; sn[i] = 0; dc[i] = 0; end
         m_done = '0; m_err = '0; m_mask = '0; m_irq = 1'b0; m_rd = '0;
         chk_en = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) m_busy[i] = (pl[i] > 0) || wt[i] || dc[i];
         if (read) begin
            case (address)
               2'd0: m_rd = {4'b0, m_busy};
               2'd1: m_rd = {4'b0, m_done};
               2'd2: m_rd = {4'b0, m_mask};
               default: m_rd = {4'b0, m_err};
            endcase
         end
         m_irq = |(m_done & m_mask);
         m_nd = '0; m_ne = '0;
         for (int i = 0; i < 4; i++) begin
            if (pl[i] > 0) begin
               if (done_in[i]) sn[i] = 1;
               pl[i]--;
               if (pl[i] == 0) begin
                  if (sn[i]) begin m_nd[i] = 1; dc[i] = 1; end
                  else begin wt[i] = 1; wa[i] = 0; end
               end
            end else if (wt[i]) begin
               if (done_in[i]) begin wt[i] = 0; m_nd[i] = 1; dc[i] = 1; end
               else begin
                  wa[i]++;
                  if (TO_ON && wa[i] == TO) begin wt[i] = 0; m_nd[i] = 1; m_ne[i] = 1; dc[i] = 1; end
               end
            end else if (dc[i]) begin
               dc[i] = 0;
            end else if (write && address == 2'd0 && data_write[i]) begin
               pl[i] = SP; sn[i] = 0;
            end
         end
         if (read && address == 2'd1) m_done = '0;
         if (read && address == 2'd3) m_err = '0;
         m_done = m_done | m_nd;
         m_err  = m_err | m_ne;
         if (write && address == 2'd2) m_mask = data_write[3:0];
      end
   end

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model data_read", data_read, m_rd);
         check("model start_out", {4'b0, start_out}, {4'b0, pl[3] > 0, pl[2] > 0, pl[1] > 0, pl[0] > 0});
         check("model irq", {7'b0, interrupt_internal}, {7'b0, m_irq});
      end
   end

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
      @(negedge clk); address = a; read = 1'b1;
      @(negedge clk); read = 1'b0;
      check(nm, data_read, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk); address = a; data_write = d; write = 1'b1;
      @(negedge clk); write = 1'b0;
   endtask

   int c0, c1, c2;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset start_out", {4'b0, start_out}, 8'h00);
      check("reset irq", {7'b0, interrupt_internal}, 8'h00);
      for (int a = 0; a < 4; a++) rd(a[1:0], 8'h00, "reset read");

      // two channels started together, pulse width counted
      wr(2'd0, 8'h05);
      c0 = 0; c2 = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (start_out[0]) c0++;
         if (start_out[2]) c2++;
         if (k == 1) begin address = 2'd0; read = 1'b1; end
         if (k == 2) begin read = 1'b0; check("ctrl busy in pulse", data_read, 8'h05); end
      end
      check("ch0 pulse len", 8'(c0), 8'd20);
      check("ch2 pulse len", 8'(c2), 8'd20);
      @(negedge clk); done_in = 4'h5;
      @(negedge clk); done_in = 4'h0;
      rd(2'd1, 8'h05, "status ch0 ch2");
      rd(2'd1, 8'h00, "status cleared");

      // interrupt path
      wr(2'd2, 8'h01);
      wr(2'd0, 8'h01);
      repeat (25) @(negedge clk);
      done_in = 4'h1;
      @(negedge clk); done_in = 4'h0;
      check("irq one cycle after", {7'b0, interrupt_internal}, 8'h00);
      @(negedge clk);
      check("irq two cycles after", {7'b0, interrupt_internal}, 8'h01);
      rd(2'd1, 8'h01, "status irq");
      rd(2'd1, 8'h00, "status irq cleared");
      check("irq dropped", {7'b0, interrupt_internal}, 8'h00);
      rd(2'd2, 8'h01, "mask readback");

      // done during pulse skips WAIT; restart during pulse ignored
      @(negedge clk); address = 2'd0; data_write = 8'h02; write = 1'b1;
      c1 = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) write = 1'b0;
         if (start_out[1]) c1++;
         if (k == 5) done_in[1] = 1'b1;
         if (k == 6) done_in[1] = 1'b0;
         if (k == 8) begin address = 2'd0; data_write = 8'h02; write = 1'b1; end
         if (k == 9) write = 1'b0;
      end
      check("ch1 pulse len", 8'(c1), 8'd20);
      rd(2'd0, 8'h00, "ch1 not waiting");
      rd(2'd1, 8'h02, "status ch1");

      // read-clear coincides with done entry: set wins
      @(negedge clk); address = 2'd0; data_write = 8'h08; write = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (k == 1) write = 1'b0;
         if (k == 3) done_in[3] = 1'b1;
         if (k == 4) done_in[3] = 1'b0;
         if (k == 20) begin address = 2'd1; read = 1'b1; end
         if (k == 21) begin read = 1'b0; check("status at done entry", data_read, 8'h00); end
      end
      rd(2'd1, 8'h08, "status set wins");

      // reset mid-operation
      wr(2'd0, 8'h01);
      repeat (3) @(negedge clk);
      check("pulse before reset", {4'b0, start_out}, 8'h01);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("start_out after reset", {4'b0, start_out}, 8'h00);
      rd(2'd0, 8'h00, "busy after reset");
      rd(2'd2, 8'h00, "mask after reset");

      // simultaneous read/write, unused bits, ignored writes
      @(negedge clk); address = 2'd2; data_write = 8'h0F; write = 1'b1; read = 1'b1;
      @(negedge clk); write = 1'b0; read = 1'b0;
      check("read during write", data_read, 8'h00);
      rd(2'd2, 8'h0F, "mask written");
      wr(2'd2, 8'hFF);
      rd(2'd2, 8'h0F, "mask upper bits");
      wr(2'd1, 8'hFF);
      wr(2'd3, 8'hFF);
      rd(2'd1, 8'h00, "status write ignored");
      rd(2'd3, 8'h00, "error write ignored");

      // WAIT with no completion: watchdog or indefinite wait
      wr(2'd0, 8'h04);
      repeat (33) @(negedge clk);
      rd(2'd1, 8'h00, "status before timeout");
      repeat (5) @(negedge clk);
      if (TO_ON) begin
         rd(2'd3, 8'h04, "error timeout");
         rd(2'd1, 8'h04, "status timeout");
         rd(2'd3, 8'h00, "error cleared");
      end else begin
         rd(2'd3, 8'h00, "error disabled");
         rd(2'd0, 8'h04, "still waiting");
         @(negedge clk); done_in = 4'h4;
         @(negedge clk); done_in = 4'h0;
         rd(2'd1, 8'h04, "status late done");
      end
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
